// File: rtl/macc_channel_scheduler_pkg.sv
// Shared definitions for the multi-channel polyphase MACC scheduler.
//   schedState_e : controller states (idle / running a job)
//   clog2        : ceil(log2(value)), usable in constant expressions
//   widthOf      : clog2 clamped to at least one bit, for vector widths
//   CHAN_W, ADDR_W, PHASE_W, TAP_W : widths for the default configuration
//                  (2 channels, 16 taps, interpolation by 2)
package macc_channel_scheduler_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } schedState_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned widthOf(input int unsigned value);
        return (value <= 1) ? 1 : clog2(value);
    endfunction

    localparam int unsigned CHAN_W  = widthOf(2);
    localparam int unsigned ADDR_W  = widthOf(2) + widthOf(16);
    localparam int unsigned PHASE_W = widthOf(2);
    localparam int unsigned TAP_W   = widthOf(16 / 2);

endpackage

// File: rtl/macc_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter over the per-channel pending flags.
// The search starts at the channel after lastServed_i and wraps, so the
// channel served most recently has the lowest priority.
//   pending_i     : one bit per channel with a queued job
//   lastServed_i  : channel granted most recently
//   grantOneHot_o : one-hot grant (all zero when nothing is pending)
//   grantIdx_o    : binary index of the granted channel
//   grantValid_o  : a channel was granted
module macc_channel_scheduler_rr_arbiter
    import macc_channel_scheduler_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    localparam int unsigned ChanW = widthOf(NumChannels)
) (
    input  logic [NumChannels-1:0] pending_i,
    input  logic [ChanW-1:0]       lastServed_i,
    output logic [NumChannels-1:0] grantOneHot_o,
    output logic [ChanW-1:0]       grantIdx_o,
    output logic                   grantValid_o
);

    // Candidate channels in priority order; wrap comes free from the
    // power-of-two channel count.
    logic [ChanW-1:0] candidate [NumChannels];

    for (genvar g = 0; g < NumChannels; g++) begin : genCandidate
        assign candidate[g] = lastServed_i + ChanW'(g + 1);
    end

    always_comb begin
        grantOneHot_o = '0;
        grantIdx_o    = '0;
        grantValid_o  = 1'b0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (!grantValid_o && pending_i[candidate[i]]) begin
                grantValid_o                = 1'b1;
                grantIdx_o                  = candidate[i];
                grantOneHot_o[candidate[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/macc_channel_scheduler.sv
// Control block sharing one single-MACC polyphase interpolator between
// NumChannels input streams. Tracks per-channel write pointers into a
// channel-partitioned data bank, queues one job per channel, picks jobs
// round-robin and walks the polyphase tap loop, tagging each completed phase
// with its channel and phase index MaccLatency cycles after its last tap.
//   Clk_i, Rst_i   : clock, asynchronous active-high reset
//   DataNd_i       : new sample strobe, DataChan_i selects the channel
//   DataWr_o       : data-bank write enable (combinational from DataNd_i)
//   DataAddrWr_o   : data-bank write address {channel, write pointer}
//   DataAddr_o     : data-bank read address {channel, newest - tap}
//   CoeffAddr_o    : coefficient address tap * K + phase
//   StartAcc_o     : first tap of a phase, MACC restarts accumulation
//   DataValid_o    : MACC output holds a finished phase (Chan_o, Phase_o)
//   Busy_o         : a job is running
//   Overrun_o      : sticky per-channel flag, sample arrived with job queued
module macc_channel_scheduler
    import macc_channel_scheduler_pkg::*;
#(
    parameter int unsigned NumChannels    = 2,
    parameter int unsigned FilterLength   = 16,
    parameter int unsigned InterpolationK = 2,
    parameter int unsigned MaccLatency    = 3,
    localparam int unsigned ChanW  = widthOf(NumChannels),
    localparam int unsigned PtrW   = widthOf(FilterLength),
    localparam int unsigned AddrW  = ChanW + PtrW,
    localparam int unsigned PhaseW = widthOf(InterpolationK)
) (
    input  logic                   Clk_i,
    input  logic                   Rst_i,
    input  logic                   DataNd_i,
    input  logic [ChanW-1:0]       DataChan_i,
    output logic                   DataWr_o,
    output logic [AddrW-1:0]       DataAddrWr_o,
    output logic [AddrW-1:0]       DataAddr_o,
    output logic [PtrW-1:0]        CoeffAddr_o,
    output logic                   StartAcc_o,
    output logic                   DataValid_o,
    output logic [ChanW-1:0]       Chan_o,
    output logic [PhaseW-1:0]      Phase_o,
    output logic                   Busy_o,
    output logic [NumChannels-1:0] Overrun_o
);

    localparam int unsigned TapsPerPhase = FilterLength / InterpolationK;
    localparam int unsigned TapW         = widthOf(TapsPerPhase);

    localparam logic [TapW-1:0]   LastTap   = TapW'(TapsPerPhase - 1);
    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(InterpolationK - 1);
    localparam logic [ChanW-1:0]  LastChan  = ChanW'(NumChannels - 1);

    schedState_e            stateQ, stateD;
    logic [ChanW-1:0]       chanQ, chanD;
    logic [ChanW-1:0]       lastServedQ, lastServedD;
    logic [PtrW-1:0]        snapQ, snapD;
    logic [PhaseW-1:0]      phaseQ, phaseD;
    logic [TapW-1:0]        tapQ, tapD, tapNext;
    logic [PtrW-1:0]        wrPtrQ [NumChannels];
    logic [PtrW-1:0]        wrPtrD [NumChannels];
    logic [NumChannels-1:0] pendingQ, pendingD;
    logic [NumChannels-1:0] overrunQ, overrunD;
    logic [AddrW-1:0]       dataAddrQ, dataAddrD;
    logic [PtrW-1:0]        coeffAddrQ, coeffAddrD;
    logic                   startAccQ, startAccD;
    logic                   grantTake, lastTapNow;

    logic [NumChannels-1:0] grantOneHot;
    logic [ChanW-1:0]       grantIdx;
    logic                   grantValid;

    // Result tags travel alongside the MACC pipeline.
    logic [MaccLatency-1:0] tagValidQ;
    logic [ChanW-1:0]       tagChanQ  [MaccLatency];
    logic [PhaseW-1:0]      tagPhaseQ [MaccLatency];

    macc_channel_scheduler_rr_arbiter #(
        .NumChannels (NumChannels)
    ) uArb (
        .pending_i     (pendingQ),
        .lastServed_i  (lastServedQ),
        .grantOneHot_o (grantOneHot),
        .grantIdx_o    (grantIdx),
        .grantValid_o  (grantValid)
    );

    assign tapNext = tapQ + TapW'(1);

    // Job sequencing: the registered address outputs always show the tap
    // currently being issued, so each transition computes the next tap.
    always_comb begin
        stateD      = stateQ;
        chanD       = chanQ;
        lastServedD = lastServedQ;
        snapD       = snapQ;
        phaseD      = phaseQ;
        tapD        = tapQ;
        dataAddrD   = dataAddrQ;
        coeffAddrD  = coeffAddrQ;
        startAccD   = 1'b0;
        grantTake   = 1'b0;
        lastTapNow  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (grantValid) begin
                    grantTake   = 1'b1;
                    stateD      = StRun;
                    chanD       = grantIdx;
                    lastServedD = grantIdx;
                    // Pre-write pointer minus one is the newest stored sample.
                    snapD       = wrPtrQ[grantIdx] - PtrW'(1);
                    phaseD      = '0;
                    tapD        = '0;
                    dataAddrD   = {grantIdx, wrPtrQ[grantIdx] - PtrW'(1)};
                    coeffAddrD  = '0;
                    startAccD   = 1'b1;
                end
            end
            StRun: begin
                lastTapNow = (tapQ == LastTap);
                if (lastTapNow) begin
                    if (phaseQ == LastPhase) begin
                        stateD = StIdle;
                    end else begin
                        phaseD     = phaseQ + PhaseW'(1);
                        tapD       = '0;
                        startAccD  = 1'b1;
                        dataAddrD  = {chanQ, snapQ};
                        coeffAddrD = PtrW'(phaseQ) + PtrW'(1);
                    end
                end else begin
                    tapD       = tapNext;
                    dataAddrD  = {chanQ, snapQ - PtrW'(tapNext)};
                    coeffAddrD = PtrW'(tapNext) * PtrW'(InterpolationK) + PtrW'(phaseQ);
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Write pointers and job bookkeeping. A strobe on the channel being
    // granted re-queues it: the set below overrides the grant's clear.
    always_comb begin
        pendingD = pendingQ;
        overrunD = overrunQ;
        wrPtrD   = wrPtrQ;
        if (grantTake) begin
            pendingD = pendingD & ~grantOneHot;
        end
        if (DataNd_i) begin
            if (pendingQ[DataChan_i]) begin
                overrunD[DataChan_i] = 1'b1;
            end
            pendingD[DataChan_i] = 1'b1;
            wrPtrD[DataChan_i]   = wrPtrQ[DataChan_i] + PtrW'(1);
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            stateQ      <= StIdle;
            chanQ       <= '0;
            lastServedQ <= LastChan;
            snapQ       <= '0;
            phaseQ      <= '0;
            tapQ        <= '0;
            pendingQ    <= '0;
            overrunQ    <= '0;
            dataAddrQ   <= '0;
            coeffAddrQ  <= '0;
            startAccQ   <= 1'b0;
            for (int i = 0; i < NumChannels; i++) begin
                wrPtrQ[i] <= '0;
            end
        end else begin
            stateQ      <= stateD;
            chanQ       <= chanD;
            lastServedQ <= lastServedD;
            snapQ       <= snapD;
            phaseQ      <= phaseD;
            tapQ        <= tapD;
            pendingQ    <= pendingD;
            overrunQ    <= overrunD;
            dataAddrQ   <= dataAddrD;
            coeffAddrQ  <= coeffAddrD;
            startAccQ   <= startAccD;
            wrPtrQ      <= wrPtrD;
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            tagValidQ <= '0;
            for (int i = 0; i < MaccLatency; i++) begin
                tagChanQ[i]  <= '0;
                tagPhaseQ[i] <= '0;
            end
        end else begin
            tagValidQ[0] <= lastTapNow;
            tagChanQ[0]  <= chanQ;
            tagPhaseQ[0] <= phaseQ;
            for (int i = 1; i < MaccLatency; i++) begin
                tagValidQ[i] <= tagValidQ[i-1];
                tagChanQ[i]  <= tagChanQ[i-1];
                tagPhaseQ[i] <= tagPhaseQ[i-1];
            end
        end
    end

    assign DataWr_o     = DataNd_i;
    assign DataAddrWr_o = {DataChan_i, wrPtrQ[DataChan_i]};
    assign DataAddr_o   = dataAddrQ;
    assign CoeffAddr_o  = coeffAddrQ;
    assign StartAcc_o   = startAccQ;
    assign DataValid_o  = tagValidQ[MaccLatency-1];
    assign Chan_o       = tagChanQ[MaccLatency-1];
    assign Phase_o      = tagPhaseQ[MaccLatency-1];
    assign Busy_o       = (stateQ == StRun);
    assign Overrun_o    = overrunQ;

endmodule
